// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: bit-error-rate checker placed after the Viterbi decoder.
// The encoder input stream is delayed by the decoder latency (DELAY) and
// compared bit-for-bit with the decoder output over a run of NUM_BITS valid
// bits. The block reports bit/error counts, the index of the first error and
// a pass flag.
// Optional build macro BER_BURST_TRACK_EN adds max_burst_o, the longest run
// of consecutive mismatching compares.
module viterbi_ber_checker #(
  parameter int DELAY    = 8,
  parameter int NUM_BITS = 256,
  parameter int CW       = 16,
  parameter int MAX_ERR  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          ref_valid_i,
  input  logic          ref_bit_i,
  input  logic          dec_bit_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [CW-1:0] bit_ct_o,
  output logic [CW-1:0] err_ct_o,
  output logic [CW-1:0] first_err_o
`ifdef BER_BURST_TRACK_EN
  ,
  output logic [CW-1:0] max_burst_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [CW-1:0] ALL_ONES = {CW{1'b1}};
  localparam logic [CW-1:0] ZERO     = {CW{1'b0}};

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == ALL_ONES) begin
      return v;
    end else begin
      return v + CW'(1);
    end
  endfunction

  state_e        state_q, state_d;
  logic [DELAY-1:0] dv_q, dv_d;
  logic [DELAY-1:0] db_q, db_d;
  logic [CW-1:0] bit_ct_q, bit_ct_d;
  logic [CW-1:0] err_ct_q, err_ct_d;
  logic [CW-1:0] first_err_q, first_err_d;
  logic          pass_q, pass_d;

  logic tap_v_s;
  logic tap_b_s;
  logic cmp_s;
  logic mismatch_s;
  logic last_s;

  assign tap_v_s    = dv_q[DELAY-1];
  assign tap_b_s    = db_q[DELAY-1];
  assign cmp_s      = (state_q == ST_RUN) && tap_v_s;
  assign mismatch_s = (tap_b_s != dec_bit_i);
  assign last_s     = (bit_ct_q == CW'(NUM_BITS - 1));

  // Delay line: shift every cycle; start_i drops older valids but keeps the new sample.
  always_comb begin
    dv_d    = dv_q;
    db_d    = db_q;
    dv_d[0] = ref_valid_i;
    db_d[0] = ref_bit_i;
    for (int i = 1; i < DELAY; i++) begin
      dv_d[i] = start_i ? 1'b0 : dv_q[i-1];
      db_d[i] = db_q[i-1];
    end
  end

  // Delay line registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q <= {DELAY{1'b0}};
      db_q <= {DELAY{1'b0}};
    end else begin
      dv_q <= dv_d;
      db_q <= db_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start_i always (re)enters RUN, even over the final compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (start_i)               state_d = ST_RUN;
        else if (cmp_s && last_s)  state_d = ST_DONE;
        else                       state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        done_o = 1'b0;
      end
      ST_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Result counters: clear on start, otherwise update on each compare event.
  always_comb begin
    bit_ct_d    = bit_ct_q;
    err_ct_d    = err_ct_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    if (start_i) begin
      bit_ct_d    = ZERO;
      err_ct_d    = ZERO;
      first_err_d = ALL_ONES;
      pass_d      = 1'b0;
    end else if (cmp_s) begin
      bit_ct_d = bit_ct_q + CW'(1);
      if (mismatch_s) begin
        err_ct_d = sat_inc(err_ct_q);
        // A zero error count means this mismatch is the first of the run.
        if (err_ct_q == ZERO) first_err_d = bit_ct_q;
        else                  first_err_d = first_err_q;
      end else begin
        err_ct_d = err_ct_q;
      end
      if (last_s) pass_d = (err_ct_d <= CW'(MAX_ERR));
      else        pass_d = pass_q;
    end else begin
      bit_ct_d = bit_ct_q;
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct_q    <= ZERO;
      err_ct_q    <= ZERO;
      first_err_q <= ALL_ONES;
      pass_q      <= 1'b0;
    end else begin
      bit_ct_q    <= bit_ct_d;
      err_ct_q    <= err_ct_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign bit_ct_o    = bit_ct_q;
  assign err_ct_o    = err_ct_q;
  assign first_err_o = first_err_q;
  assign pass_o      = pass_q;

`ifdef BER_BURST_TRACK_EN
  logic [CW-1:0] cur_burst_q, cur_burst_d;
  logic [CW-1:0] max_burst_q, max_burst_d;

  // Burst tracking: mismatches extend the current burst, a match ends it.
  always_comb begin
    cur_burst_d = cur_burst_q;
    max_burst_d = max_burst_q;
    if (start_i) begin
      cur_burst_d = ZERO;
      max_burst_d = ZERO;
    end else if (cmp_s) begin
      if (mismatch_s) begin
        cur_burst_d = sat_inc(cur_burst_q);
        if (cur_burst_d > max_burst_q) max_burst_d = cur_burst_d;
        else                           max_burst_d = max_burst_q;
      end else begin
        cur_burst_d = ZERO;
      end
    end else begin
      cur_burst_d = cur_burst_q;
    end
  end

  // Burst registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_burst_q <= ZERO;
      max_burst_q <= ZERO;
    end else begin
      cur_burst_q <= cur_burst_d;
      max_burst_q <= max_burst_d;
    end
  end

  assign max_burst_o = max_burst_q;
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Testbench for viterbi_ber_checker: random reference streams, a history-based
// reference model, and two DUT instances (MAX_ERR = 0 and MAX_ERR = 1).
module tb_viterbi_ber_checker;

  localparam int DELAY = 8;
  localparam int NB    = 256;
  localparam int CW    = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int BOUND  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic ref_valid_i = 1'b0;
  logic ref_bit_i = 1'b0;
  logic dec_bit_i = 1'b0;

  logic busy_o, done_o, pass_o;
  logic [CW-1:0] bit_ct_o, err_ct_o, first_err_o;
  logic busy1_o, done1_o, pass1_o;
  logic [CW-1:0] bit_ct1_o, err_ct1_o, first_err1_o;
`ifdef BER_BURST_TRACK_EN
  logic [CW-1:0] max_burst_o, max_burst1_o;
`endif

  viterbi_ber_checker #(.DELAY(DELAY), .NUM_BITS(NB), .CW(CW), .MAX_ERR(0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ref_valid_i(ref_valid_i),
    .ref_bit_i(ref_bit_i), .dec_bit_i(dec_bit_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o), .first_err_o(first_err_o)
`ifdef BER_BURST_TRACK_EN
    , .max_burst_o(max_burst_o)
`endif
  );

  viterbi_ber_checker #(.DELAY(DELAY), .NUM_BITS(NB), .CW(CW), .MAX_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .ref_valid_i(ref_valid_i),
    .ref_bit_i(ref_bit_i), .dec_bit_i(dec_bit_i), .busy_o(busy1_o), .done_o(done1_o),
    .pass_o(pass1_o), .bit_ct_o(bit_ct1_o), .err_ct_o(err_ct1_o), .first_err_o(first_err1_o)
`ifdef BER_BURST_TRACK_EN
    , .max_burst_o(max_burst1_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: per-cycle history of what was presented upstream.
  int cyc = 0;
  bit hv[8192];
  bit hb[8192];
  int m_clear;
  int m_state, m_bit, m_err, m_first, m_cur, m_max;
  bit m_pass0, m_pass1;
  bit mask[NB];
  bit gapforce = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_bit = 0; m_err = 0; m_first = 65535;
    m_cur = 0; m_max = 0; m_pass0 = 1'b0; m_pass1 = 1'b0;
    m_clear = cyc + 1;
  endtask

  task automatic check_all();
    chk("busy", 32'(busy_o), 32'(m_state == M_RUN));
    chk("done", 32'(done_o), 32'(m_state == M_DONE));
    chk("bit_ct", 32'(bit_ct_o), m_bit);
    chk("err_ct", 32'(err_ct_o), m_err);
    chk("first_err", 32'(first_err_o), m_first);
    chk("pass", 32'(pass_o), 32'(m_pass0));
    chk("pass_maxerr1", 32'(pass1_o), 32'(m_pass1));
`ifdef BER_BURST_TRACK_EN
    chk("max_burst", 32'(max_burst_o), m_max);
`endif
  endtask

  task automatic clr_mask();
    for (int i = 0; i < NB; i++) mask[i] = 1'b0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model, clock.
  task automatic do_cycle(input bit st, input bit rv);
    int u;
    bit tv, tb, cmp, dec, rb;
    check_all();
    u  = cyc - DELAY;
    tv = (u >= m_clear) && hv[u];
    tb = (u >= 0) ? hb[u] : 1'b0;
    cmp = (m_state == M_RUN) && tv && !st;
    if (cmp)           dec = tb ^ mask[m_bit];
    else if (gapforce) dec = ~tb;
    else               dec = 1'($urandom_range(1));
    rb = 1'($urandom_range(1));
    start_i = st; ref_valid_i = rv; ref_bit_i = rb; dec_bit_i = dec;
    if (st) begin
      m_state = M_RUN; m_bit = 0; m_err = 0; m_first = 65535;
      m_cur = 0; m_max = 0; m_pass0 = 1'b0; m_pass1 = 1'b0;
      m_clear = cyc;
    end else if (cmp) begin
      if (dec != tb) begin
        if (m_err == 0) m_first = m_bit;
        if (m_err < 65535) m_err++;
        m_cur++;
        if (m_cur > m_max) m_max = m_cur;
      end else begin
        m_cur = 0;
      end
      m_bit++;
      if (m_bit == NB) begin
        m_state = M_DONE;
        m_pass0 = (m_err <= 0);
        m_pass1 = (m_err <= 1);
      end
    end
    hv[cyc] = rv; hb[cyc] = rb;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // A run: start pulse, then cycles until DONE or stop_bits compares.
  task automatic run(input bit gap, input int stop_bits, input int density, output int done_k);
    int k;
    bit rv;
    done_k = -1;
    do_cycle(1'b1, 1'b1);
    chk("restart_bit", 32'(bit_ct_o), 32'd0);
    chk("restart_err", 32'(err_ct_o), 32'd0);
    chk("restart_busy", 32'(busy_o), 32'd1);
    k = 1;
    while (m_state != M_DONE && m_bit < stop_bits && k < BOUND) begin
      if (k == DELAY) chk("flush_bit", 32'(bit_ct_o), 32'd0);
      if (gap) rv = (k % 2 == 0);
      else     rv = ($urandom_range(99) < density);
      do_cycle(1'b0, rv);
      k++;
      if (m_state == M_DONE && done_k < 0) done_k = k;
    end
    chk("bound", 32'(k < BOUND), 32'd1);
  endtask

  initial begin
    int dk;
    model_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_bit", 32'(bit_ct_o), 32'd0);
    chk("rst_first", 32'(first_err_o), 32'hFFFF);
    rst = 1'b1;
    cyc = 1;
    clr_mask();
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1);

    // Clean loop
    run(1'b0, NB, 100, dk);
    chk("clean_done_lat", dk, 32'(NB - 1 + DELAY + 1));
    chk("clean_done", 32'(done_o), 32'd1);
    chk("clean_err", 32'(err_ct_o), 32'd0);
    chk("clean_bit", 32'(bit_ct_o), 32'(NB));
    chk("clean_first", 32'(first_err_o), 32'hFFFF);
    chk("clean_pass", 32'(pass_o), 32'd1);

    // Single error at index 37
    mask[37] = 1'b1;
    run(1'b0, NB, 100, dk);
    chk("single_err", 32'(err_ct_o), 32'd1);
    chk("single_first", 32'(first_err_o), 32'd37);
    chk("single_pass0", 32'(pass_o), 32'd0);
    chk("single_pass1", 32'(pass1_o), 32'd1);
    clr_mask();

    // Gapped valid with forced mismatch on invalid cycles
    gapforce = 1'b1;
    run(1'b1, NB, 100, dk);
    gapforce = 1'b0;
    chk("gap_done_lat", dk, 32'(2 * (NB - 1) + DELAY + 1));
    chk("gap_err", 32'(err_ct_o), 32'd0);
    chk("gap_bit", 32'(bit_ct_o), 32'(NB));

    // Restart after 100 compares with 5 errors
    mask[3] = 1'b1; mask[17] = 1'b1; mask[40] = 1'b1; mask[41] = 1'b1; mask[90] = 1'b1;
    run(1'b0, 100, 100, dk);
    do_cycle(1'b0, 1'b1);
    chk("pre_restart_err", 32'(err_ct_o), 32'd5);
    clr_mask();
    run(1'b0, NB, 100, dk);
    chk("restart_run_err", 32'(err_ct_o), 32'd0);
    chk("restart_run_bit", 32'(bit_ct_o), 32'(NB));

    // start_i on the terminating compare cycle wins
    run(1'b0, NB - 1, 100, dk);
    run(1'b0, 1, 100, dk);
    chk("start_wins_done", 32'(done_o), 32'd0);
    run(1'b0, NB, 100, dk);

    // Reset at bit 50
    mask[5] = 1'b1;
    run(1'b0, 50, 100, dk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_bit", 32'(bit_ct_o), 32'd0);
    chk("midrst_err", 32'(err_ct_o), 32'd0);
    chk("midrst_first", 32'(first_err_o), 32'hFFFF);
    model_reset();
    cyc++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clr_mask();
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b1);
    chk("idle_bit", 32'(bit_ct_o), 32'd0);

    // Two bursts: 10-12 and 20-24
    for (int i = 10; i <= 12; i++) mask[i] = 1'b1;
    for (int i = 20; i <= 24; i++) mask[i] = 1'b1;
    run(1'b0, NB, 100, dk);
    chk("burst_err", 32'(err_ct_o), 32'd8);
    chk("burst_first", 32'(first_err_o), 32'd10);
`ifdef BER_BURST_TRACK_EN
    chk("burst_max", 32'(max_burst_o), 32'd5);
`endif

    // Random runs
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NB; i++) mask[i] = ($urandom_range(99) < 4);
      run(1'b0, NB, 60, dk);
    end
    do_cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Bit-error-rate checker that sits directly downstream of the Viterbi decoder in the tx/rx loop.
- Takes the raw encoder input stream (bit + enable) as the reference and delays it by the fixed decoder latency. Compares it bit-for-bit against decoder output.
- Counts compared bits and mismatches over a run of NUM_BITS bits. Reports pass/fail and the index of the first error.
- Replaces ad-hoc $display checking in the tx/rx wrappers with a self-checking, synthesizable block.

Parameters:
- DELAY, 8: cycles from ref_bit_i sample to the corresponding dec_bit_i sample. Must be >= 1.
- NUM_BITS, 256: number of valid compared bits per run.
- CW, 16: width of all counters and index outputs. 2^CW-1 must be >= NUM_BITS.
- MAX_ERR, 0: largest err_ct_o value that still yields pass_o=1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle pulse; clears all results and starts a run
- ref_valid_i  in  1  reference bit valid (encoder enable)
- ref_bit_i  in  1  reference data bit (encoder input)
- dec_bit_i  in  1  decoder output bit, one per cycle
- busy_o  out  1  high while in RUN
- done_o  out  1  high in DONE, held until next start_i
- pass_o  out  1  registered, valid when done_o=1
- bit_ct_o  out  CW  valid bits compared this run
- err_ct_o  out  CW  mismatches this run
- first_err_o  out  CW  bit index (0-based) of first mismatch; all-ones if none

Behaviour:
- Reset (rst=0, async): state IDLE, delay line cleared (all valids 0). All outputs 0, except first_err_o = all-ones.
- Delay line: DELAY-stage shift register of {valid,bit}. Shifts every cycle regardless of state. The tap holds the ref_valid_i/ref_bit_i values presented exactly DELAY cycles earlier.
- Compare event:
  - Occurs when state=RUN and tap valid=1.
  - A mismatch is tap bit != dec_bit_i on that same cycle.
  - Tap valid=0 cycles are ignored: no counter change.
- On each compare event, the following updates take effect on the next clock edge:
  - bit_ct_o += 1.
  - If mismatch: err_ct_o += 1, saturating at 2^CW-1.
  - If mismatch and this is the first mismatch of the run: first_err_o <= bit_ct_o (pre-increment value).
- FSM:
  - IDLE: busy=0, done=0. start_i -> RUN.
  - RUN: busy=1. The compare event that brings bit_ct_o to NUM_BITS moves to DONE on the same edge.
  - DONE: busy=0, done=1. pass_o = (err_ct_o <= MAX_ERR), computed from the final count. start_i -> RUN.
- start_i in any state, including mid-RUN:
  - Takes effect on the next edge, and the FSM enters RUN on that edge.
  - Clears bit_ct_o, err_ct_o and pass_o, and sets first_err_o to all-ones.
  - Clears all delay-line valids, so stale bits are not counted. The ref_valid_i/ref_bit_i sampled on the start_i cycle itself is loaded into stage 0 as normal.
- start_i on the same cycle as the terminating compare: start_i wins. The run restarts and DONE is not entered.
- Reset mid-RUN: immediate return to reset values. No partial result is held.
- Latency:
  - A mismatch at dec_bit_i is visible on err_ct_o one cycle later.
  - done_o rises one cycle after the last compare event.

Optional Feature:
- Macro BER_BURST_TRACK_EN.
- Defined:
  - Adds output max_burst_o (CW bits, reset 0, cleared by start_i).
  - Holds the longest run of consecutive mismatching compare events.
  - A matching compare event ends the current run. Cycles without a compare event neither extend nor end it.
  - Updated on the same edge as err_ct_o; saturating.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Clean loop: DELAY=8, start_i, 256 valid random bits, dec_bit_i = ref delayed 8 cycles -> done_o after 256 compares; err_ct_o=0, bit_ct_o=256, first_err_o=16'hFFFF, pass_o=1.
- Single error: same loop, invert dec_bit_i on the compare of bit index 37 -> err_ct_o=1, first_err_o=37, pass_o=0 with MAX_ERR=0; pass_o=1 rerun with MAX_ERR=1.
- Gapped valid: ref_valid_i toggling 1,0,1,0 for 512 cycles -> bit_ct_o reaches 256 only after 511+8 cycles; invalid cycles with forced mismatching dec_bit_i do not change err_ct_o.
- Restart mid-run: start_i after 100 compares with 5 errors -> next cycle bit_ct_o=0, err_ct_o=0; the following 8 cycles produce no compare events (valids flushed); run completes with fresh counts.
- Reset mid-run: rst low for 1 cycle at bit 50 -> all outputs at reset values, state IDLE; no compares until the next start_i.
- BER_BURST_TRACK_EN: mismatch at indices 10-12 and 20-24, all others match -> err_ct_o=8, max_burst_o=5, first_err_o=10.
